bcd_seg_scan: RTL and testbench

BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

---
 rtl/bcd_seg_pkg.sv | 45 ++++
 rtl/bcd_to_seg7.sv | 34 +++
 rtl/bcd_seg_scan.sv | 152 +++++++++++++++
 tb/tb_bcd_seg_scan.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seg_pkg
// Description : Shared constants for the BCD seven-segment scanner. Holds the
//               segment patterns (gfedcba, active-high), the digit-index
//               encoding and the digit count.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_seg_pkg;

    localparam int NUM_DIGITS = 3;

    // Segment patterns, bit0 = a .. bit6 = g
    localparam logic [6:0] c_SEG_0     = 7'h3F;
    localparam logic [6:0] c_SEG_1     = 7'h06;
    localparam logic [6:0] c_SEG_2     = 7'h5B;
    localparam logic [6:0] c_SEG_3     = 7'h4F;
    localparam logic [6:0] c_SEG_4     = 7'h66;
    localparam logic [6:0] c_SEG_5     = 7'h6D;
    localparam logic [6:0] c_SEG_6     = 7'h7D;
    localparam logic [6:0] c_SEG_7     = 7'h07;
    localparam logic [6:0] c_SEG_8     = 7'h7F;
    localparam logic [6:0] c_SEG_9     = 7'h6F;
    localparam logic [6:0] c_SEG_DASH  = 7'h40;
    localparam logic [6:0] c_SEG_BLANK = 7'h00;

    // Scan position; also the selector into the packed BCD word
    typedef enum logic [1:0] {
        DIG_UNITS    = 2'd0,
        DIG_TENS     = 2'd1,
        DIG_HUNDREDS = 2'd2
    } dig_idx_e;

    // One-hot digit enable for a scan position
    function automatic logic [NUM_DIGITS-1:0] dig_onehot(input dig_idx_e idx);
        case (idx)
            DIG_UNITS:    return 3'b001;
            DIG_TENS:     return 3'b010;
            DIG_HUNDREDS: return 3'b100;
            default:      return 3'b000;
        endcase
    endfunction

endpackage : bcd_seg_pkg
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_seg7
// Description : Combinational BCD digit to seven-segment decoder. Codes above
//               9 decode to a dash so corrupted input is visible on the glass.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
    import bcd_seg_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    // Pattern lookup, dash for any non-decimal code
    always_comb begin
        o_seg = c_SEG_DASH;
        case (i_digit)
            4'd0:    o_seg = c_SEG_0;
            4'd1:    o_seg = c_SEG_1;
            4'd2:    o_seg = c_SEG_2;
            4'd3:    o_seg = c_SEG_3;
            4'd4:    o_seg = c_SEG_4;
            4'd5:    o_seg = c_SEG_5;
            4'd6:    o_seg = c_SEG_6;
            4'd7:    o_seg = c_SEG_7;
            4'd8:    o_seg = c_SEG_8;
            4'd9:    o_seg = c_SEG_9;
            default: o_seg = c_SEG_DASH;
        endcase
    end

endmodule : bcd_to_seg7
`default_nettype wire

// File: rtl/bcd_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seg_scan
// Description : Three-digit multiplexed seven-segment driver for a packed BCD
//               word {hundreds[1:0], tens[3:0], units[3:0]}. A one-deep
//               pending buffer takes new values at any time; they are moved
//               to the display only at a frame boundary so a frame never
//               mixes two values.
// Options     : BCD_SEG_LZ_BLANK_EN - blank leading zeros on tens/hundreds.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_seg_scan
    import bcd_seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            bcd_in,
    input  logic                  bcd_valid,
    output logic                  bcd_ready,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] dig_sel
);

    // Keep at least one bit so SCAN_DIV == 1 still elaborates
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0]         r_prescale;
    dig_idx_e              r_idx;
    dig_idx_e              w_idx_nxt;
    logic [9:0]            r_pending;
    logic                  r_pending_full;
    logic [9:0]            r_disp;
    logic                  r_ready;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig_sel;

    logic                  w_tick;
    logic                  w_frame_end;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_full_nxt;
    logic [3:0]            w_digit;
    logic [6:0]            w_pat;
    logic                  w_lz_blank;

    assign w_tick      = (r_prescale == PW'(SCAN_DIV - 1));
    assign w_frame_end = w_tick && (r_idx == DIG_HUNDREDS);
    assign w_accept    = bcd_valid && r_ready;
    assign w_load      = w_frame_end && r_pending_full;
    // Accept and load never coincide: ready is only high while pending is empty
    assign w_full_nxt  = w_accept || (r_pending_full && !w_load);

    // Prescaler: terminal count produces the scan tick
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prescale <= '0;
        end else if (w_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    // Scan position register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx <= DIG_UNITS;
        end else begin
            r_idx <= w_idx_nxt;
        end
    end

    // Scan position sequencing: units -> tens -> hundreds on each tick
    always_comb begin
        w_idx_nxt = r_idx;
        if (w_tick) begin
            case (r_idx)
                DIG_UNITS:    w_idx_nxt = DIG_TENS;
                DIG_TENS:     w_idx_nxt = DIG_HUNDREDS;
                default:      w_idx_nxt = DIG_UNITS;
            endcase
        end
    end

    // Pending buffer, frame-aligned display update and registered ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            r_disp         <= '0;
            r_ready        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pending <= bcd_in;
            end
            if (w_load) begin
                r_disp <= r_pending;
            end
            r_pending_full <= w_full_nxt;
            r_ready        <= !w_full_nxt;
        end
    end

    // Select the digit under scan; hundreds code 3 is forced to a dash code
    always_comb begin
        w_digit = 4'hF;
        case (r_idx)
            DIG_UNITS:    w_digit = r_disp[3:0];
            DIG_TENS:     w_digit = r_disp[7:4];
            DIG_HUNDREDS: w_digit = (r_disp[9:8] == 2'd3) ? 4'hF : {2'b00, r_disp[9:8]};
            default:      w_digit = 4'hF;
        endcase
    end

    bcd_to_seg7 u_dec (
        .i_digit (w_digit),
        .o_seg   (w_pat)
    );

`ifdef BCD_SEG_LZ_BLANK_EN
    // Leading-zero suppression; units always shown
    always_comb begin
        w_lz_blank = 1'b0;
        case (r_idx)
            DIG_TENS:     w_lz_blank = (r_disp[9:8] == 2'd0) && (r_disp[7:4] == 4'd0);
            DIG_HUNDREDS: w_lz_blank = (r_disp[9:8] == 2'd0);
            default:      w_lz_blank = 1'b0;
        endcase
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    // Output registers: one cycle behind the scan position
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg     <= c_SEG_BLANK;
            r_dig_sel <= '0;
        end else begin
            r_seg     <= w_lz_blank ? c_SEG_BLANK : w_pat;
            r_dig_sel <= dig_onehot(r_idx);
        end
    end

    assign bcd_ready = r_ready;
    assign seg       = r_seg;
    assign dig_sel   = r_dig_sel;

endmodule : bcd_seg_scan
`default_nettype wire

// File: tb/tb_bcd_seg_scan.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bcd_seg_scan
// Description : Scoreboard bench for bcd_seg_scan. Instance A (SCAN_DIV=4)
//               exercises reset release; instance B (SCAN_DIV=2) exercises
//               load, back-pressure, illegal digits, blanking and mid-frame
//               reset. Expected outputs are queued by the stimulus and
//               popped by a monitor on the falling edge.
// Options     : BCD_SEG_LZ_BLANK_EN - selects blanked leading-zero patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_seg_scan;

`ifdef BCD_SEG_LZ_BLANK_EN
    localparam logic [6:0] ZLZ = 7'h00;
`else
    localparam logic [6:0] ZLZ = 7'h3F;
`endif

    typedef struct packed {
        logic [2:0] dig;
        logic [6:0] seg;
        logic       rdy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n_a = 1'b0;
    logic       rst_n_b = 1'b0;
    logic [9:0] bcd_in = '0;
    logic       bcd_valid = 1'b0;
    logic       rdy_a, rdy_b;
    logic [6:0] seg_a, seg_b;
    logic [2:0] dig_a, dig_b;

    exp_t  qa[$];
    exp_t  qb[$];
    string na[$];
    string nb[$];
    exp_t  ea, eb;
    string sa, sb;
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    bcd_seg_scan #(.SCAN_DIV(4)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n_a),
        .bcd_in    (bcd_in),
        .bcd_valid (1'b0),
        .bcd_ready (rdy_a),
        .seg       (seg_a),
        .dig_sel   (dig_a)
    );

    bcd_seg_scan #(.SCAN_DIV(2)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n_b),
        .bcd_in    (bcd_in),
        .bcd_valid (bcd_valid),
        .bcd_ready (rdy_b),
        .seg       (seg_b),
        .dig_sel   (dig_b)
    );

    task automatic check(input string who, input string nm, input exp_t e,
                         input logic [2:0] d, input logic [6:0] s, input logic r);
        n_tests++;
        if (d !== e.dig || s !== e.seg || r !== e.rdy) begin
            n_fail++;
            $display("FAIL %s %s: got dig_sel=%b seg=%h bcd_ready=%b, expected dig_sel=%b seg=%h bcd_ready=%b",
                     who, nm, d, s, r, e.dig, e.seg, e.rdy);
        end
    endtask

    // Monitor: compare whatever is queued for this cycle
    always @(negedge clk) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            sa = na.pop_front();
            check("A", sa, ea, dig_a, seg_a, rdy_a);
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            sb = nb.pop_front();
            check("B", sb, eb, dig_b, seg_b, rdy_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_a(input string nm, input logic [2:0] d, input logic [6:0] s, input logic r);
        qa.push_back('{dig: d, seg: s, rdy: r});
        na.push_back(nm);
    endtask

    task automatic exp_b(input string nm, input logic [2:0] d, input logic [6:0] s, input logic r);
        qb.push_back('{dig: d, seg: s, rdy: r});
        nb.push_back(nm);
    endtask

    // One SCAN_DIV=2 frame on B: expected output per edge plus the stimulus
    // applied after the first two edges of the frame.
    task automatic frame_b(input string nm, input logic ld, input logic [9:0] v,
                           input logic h2, input logic [9:0] v2,
                           input logic [6:0] u, input logic [6:0] t, input logic [6:0] h,
                           input logic [5:0] rdy);
        logic [2:0] d;
        logic [6:0] s;
        for (int i = 0; i < 6; i++) begin
            tick();
            d = (i < 2) ? 3'b001 : ((i < 4) ? 3'b010 : 3'b100);
            s = (i < 2) ? u : ((i < 4) ? t : h);
            exp_b($sformatf("%s[%0d]", nm, i), d, s, rdy[i]);
            if (i == 0) begin
                bcd_valid = ld;
                if (ld) bcd_in = v;
            end else if (i == 1) begin
                bcd_valid = h2;
                if (h2) bcd_in = v2;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] d;
        logic [6:0] s;

        // Both held in reset
        repeat (3) begin
            tick();
            exp_a("reset", 3'b000, 7'h00, 1'b0);
            exp_b("reset", 3'b000, 7'h00, 1'b0);
        end
        rst_n_a = 1'b1;

        // A released with SCAN_DIV=4, B still held in reset
        for (int i = 0; i < 16; i++) begin
            tick();
            case (i / 4)
                0:       d = 3'b001;
                1:       d = 3'b010;
                2:       d = 3'b100;
                default: d = 3'b001;
            endcase
            s = (d == 3'b001) ? 7'h3F : ZLZ;
            exp_a($sformatf("release_div4[%0d]", i), d, s, 1'b1);
            exp_b("held_reset", 3'b000, 7'h00, 1'b0);
        end
        rst_n_b = 1'b1;

        // B: load 255 in first frame, shown from the following frame
        frame_b("load255",   1'b1, 10'b10_0101_0101, 1'b0, 10'd0, 7'h3F, ZLZ,   ZLZ,   6'b100001);
        frame_b("show255",   1'b0, 10'd0,            1'b0, 10'd0, 7'h6D, 7'h6D, 7'h5B, 6'b111111);
        // 123 accepted, 045 held off until the boundary
        frame_b("bp_123",    1'b1, 10'b01_0010_0011, 1'b1, 10'b00_0100_0101,
                7'h6D, 7'h6D, 7'h5B, 6'b100001);
        frame_b("show123",   1'b0, 10'd0,            1'b0, 10'd0, 7'h4F, 7'h5B, 7'h06, 6'b100000);
        frame_b("show045",   1'b1, 10'b11_1010_1111, 1'b0, 10'd0, 7'h6D, 7'h66, ZLZ,   6'b100001);
        frame_b("illegal",   1'b1, 10'b00_0000_0111, 1'b0, 10'd0, 7'h40, 7'h40, 7'h40, 6'b100001);
        frame_b("lz_7",      1'b0, 10'd0,            1'b0, 10'd0, 7'h07, ZLZ,   ZLZ,   6'b111111);

        // Reset mid-frame with pending full
        tick(); exp_b("rstmid[0]", 3'b001, 7'h07, 1'b1);
        bcd_valid = 1'b1;
        bcd_in    = 10'b10_0101_0101;
        tick(); exp_b("rstmid[1]", 3'b001, 7'h07, 1'b0);
        bcd_valid = 1'b0;
        tick(); exp_b("rstmid[2]", 3'b010, ZLZ, 1'b0);
        tick(); exp_b("rstmid[3]", 3'b010, ZLZ, 1'b0);
        rst_n_b = 1'b0;
        tick(); exp_b("rstmid_reset", 3'b000, 7'h00, 1'b0);
        rst_n_b = 1'b1;

        frame_b("after_rst", 1'b0, 10'd0, 1'b0, 10'd0, 7'h3F, ZLZ, ZLZ, 6'b111111);
        frame_b("discarded", 1'b0, 10'd0, 1'b0, 10'd0, 7'h3F, ZLZ, ZLZ, 6'b111111);

        @(negedge clk);
        #1;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d/%0d entries left, expected 0/0", qa.size(), qb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bcd_seg_scan
`default_nettype wire
